// File: rtl/dwrr_pkg.sv
// Shared definitions for the DWRR arbiter and its requestor-side queues:
// default sizing and the one-hot check used by both the RTL and the benches.
package dwrr_pkg;

    localparam int DFLT_NUM_REQS = 4;
    localparam int DFLT_QWID     = 4;   // arbiter quantum width
    localparam int DFLT_PSIZE    = 8;   // arbiter packet-size credit
    localparam int DFLT_DWID     = 8;
    localparam int DFLT_DEPTH    = 4;
    localparam int VECW          = 32;  // widest vector the one-hot check accepts

    // Source-index width; a single flow still needs one bit to carry an index.
    function automatic int cntwid(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when at most one bit of v is set.
    function automatic logic is_onehot0(input logic [VECW-1:0] v);
        return ((v & (v - VECW'(1))) == '0);
    endfunction

endpackage

// File: rtl/dwrr_flow_fifo.sv
// Single-flow synchronous FIFO: circular buffer with separate read/write
// pointers and an explicit occupancy count. Head data is presented combinationally.
module dwrr_flow_fifo #(
    parameter int DWID   = 8,
    parameter int DEPTH  = 4,
    parameter int PTRWID = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWID-1:0]   wr_data,
    input  logic              rd_en,
    output logic [DWID-1:0]   rd_data,
    output logic              full,
    output logic              empty,
    output logic [PTRWID:0]   count
);

    localparam logic [PTRWID:0]   CNT_FULL = (PTRWID+1)'(DEPTH);
    localparam logic [PTRWID:0]   CNT_ONE  = (PTRWID+1)'(1);
    localparam logic [PTRWID-1:0] PTR_ONE  = PTRWID'(1);

    logic [DWID-1:0]   mem_q [DEPTH];
    logic [PTRWID-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRWID-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRWID:0]   count_q, count_d;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Full is judged before any same-cycle pop, so a push into a full queue
    // is dropped even while the head is leaving.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read from a slot before it is written.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/dwrr_req_queues.sv
// Requestor-side queues for the DWRR arbiter: per-flow FIFOs drive reqs, and
// the granted flow's head packet is popped onto one registered egress port.
module dwrr_req_queues
    import dwrr_pkg::*;
#(
    parameter int NUM_REQS = dwrr_pkg::DFLT_NUM_REQS,
    parameter int DWID     = dwrr_pkg::DFLT_DWID,
    parameter int DEPTH    = dwrr_pkg::DFLT_DEPTH,
    parameter int PTRWID   = $clog2(DEPTH),
    parameter int CNTWID   = dwrr_pkg::cntwid(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQS-1:0]            push,
    input  logic [NUM_REQS*DWID-1:0]       push_data,
    output logic [NUM_REQS-1:0]            full,
    output logic [NUM_REQS*(PTRWID+1)-1:0] occ,
    input  logic                           stall,
    output logic [NUM_REQS-1:0]            reqs,
    input  logic [NUM_REQS-1:0]            gnt,
    output logic                           out_valid,
    output logic [DWID-1:0]                out_data,
    output logic [CNTWID-1:0]              out_src,
    output logic                           proto_err
);

    // Handshake: reqs[i] is the valid of flow i and gnt is its acceptance; a
    // pop happens only when gnt is one-hot, a subset of reqs, and stall=0.
    // The egress port has no ready: out_valid is a one-cycle pulse, and
    // downstream backpressure is applied only through stall.

    logic [DWID-1:0]   rd_data_w [NUM_REQS];
    logic [NUM_REQS-1:0] empty_w;
    logic [NUM_REQS-1:0] pop_w;
    logic [PTRWID:0]   count_w [NUM_REQS];

    logic              gnt_any;
    logic              gnt_onehot;
    logic              gnt_ok;
    logic              gnt_err;
    logic [DWID-1:0]   sel_data;
    logic [CNTWID-1:0] sel_src;

    logic              out_valid_q, out_valid_d;
    logic [DWID-1:0]   out_data_q, out_data_d;
    logic [CNTWID-1:0] out_src_q, out_src_d;
    logic              proto_err_q, proto_err_d;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_flow
        dwrr_flow_fifo #(
            .DWID   (DWID),
            .DEPTH  (DEPTH),
            .PTRWID (PTRWID)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (push[g]),
            .wr_data (push_data[g*DWID +: DWID]),
            .rd_en   (pop_w[g]),
            .rd_data (rd_data_w[g]),
            .full    (full[g]),
            .empty   (empty_w[g]),
            .count   (count_w[g])
        );
        assign occ[g*(PTRWID+1) +: (PTRWID+1)] = count_w[g];
    end

    assign reqs = ~empty_w & {NUM_REQS{~stall}};

    always_comb begin
        gnt_any    = |gnt;
        gnt_onehot = is_onehot0(VECW'(gnt));
        gnt_ok     = gnt_any && gnt_onehot && ((gnt & ~reqs) == '0);
        gnt_err    = gnt_any && !gnt_ok;
        pop_w      = gnt & {NUM_REQS{gnt_ok}};
    end

    // Egress mux: only consumed when the grant is one-hot, so at most one match.
    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (gnt[i]) begin
                sel_data = rd_data_w[i];
                sel_src  = CNTWID'(i);
            end
        end
    end

    always_comb begin
        out_valid_d = gnt_ok;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        proto_err_d = proto_err_q | gnt_err;
        if (gnt_ok) begin
            out_data_d = sel_data;
            out_src_d  = sel_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign proto_err = proto_err_q;

endmodule
